// File: rtl/spi_pkg.sv
// Shared SPI link definitions: controller state encoding, frame size and register address map limits.
package spi_pkg;
   typedef enum logic [2:0] {IDLE, SHIFT, GAP, ERR, RESP} spi_ctrl_state_t;

   localparam int         FRAME_BITS   = 16;
   localparam logic [7:0] RW_ADDR_MIN  = 8'd1;
   localparam logic [7:0] RW_ADDR_MAX  = 8'd3;
   localparam logic [7:0] REG_ADDR_MAX = 8'd59;

   // Writes may only target the programmable regs; reads cover the whole populated map.
   function automatic logic cmd_illegal(input logic write, input logic [7:0] addr);
      return (addr == 8'd0) || (addr > REG_ADDR_MAX) ||
             (write && ((addr < RW_ADDR_MIN) || (addr > RW_ADDR_MAX)));
   endfunction
endpackage

// File: rtl/spi_sclk_gen.sv
// Mode-0 sclk generator: CLK_DIV iclk cycles per half period, with strobes flagging the next edge.
module spi_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic iclk,
   input  logic rstn,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);
   localparam int             HW     = $clog2(CLK_DIV + 1);
   localparam logic [HW-1:0]  RELOAD = HW'(CLK_DIV - 1);

   logic [HW-1:0] half_cnt;
   logic          tc;

   // Strobes are high in the cycle whose closing edge moves sclk.
   assign tc   = en && (half_cnt == '0);
   assign rise = tc && !sclk;
   assign fall = tc && sclk;

   always_ff @(posedge iclk or negedge rstn) begin
      if (!rstn) begin
         half_cnt <= '0;
         sclk     <= 1'b0;
      end else if (!en) begin
         half_cnt <= RELOAD;
         sclk     <= 1'b0;
      end else if (tc) begin
         half_cnt <= RELOAD;
         sclk     <= ~sclk;
      end else begin
         half_cnt <= half_cnt - HW'(1);
      end
   end
endmodule

// File: rtl/spi_controller.sv
// SPI initiator: turns single-register commands into 16-bit address/data frames and returns read data.
module spi_controller
   import spi_pkg::*;
#(
   parameter int CLK_DIV     = 4,
   parameter int IDLE_CYCLES = 16
) (
   input  logic       iclk,
   input  logic       rstn,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic       rsp_err,
   output logic [7:0] rsp_rdata,
   output logic       busy,
   output logic       sclk,
   output logic       pico,
   input  logic       poci
);
   // state | meaning
   // IDLE  | waiting for a command, cmd_ready high
   // SHIFT | frame on the wire, 16 sclk pulses
   // GAP   | sclk held low so the target sees the frame end
   // ERR   | illegal command, no frame sent
   // RESP  | one-cycle rsp_valid
   localparam int GW = $clog2(IDLE_CYCLES + 1);

   spi_ctrl_state_t       state;
   logic [FRAME_BITS-1:0] tx_sr;
   logic [7:0]            rx_sr;
   logic [3:0]            bit_cnt;
   logic [GW-1:0]         gap_cnt;
   logic                  is_write;
   logic                  shift_en;
   logic                  sclk_rise;
   logic                  sclk_fall;

   assign shift_en = (state == SHIFT);

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .iclk (iclk),
      .rstn (rstn),
      .en   (shift_en),
      .sclk (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   always_ff @(posedge iclk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         tx_sr     <= '0;
         rx_sr     <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         is_write  <= 1'b0;
         pico      <= 1'b0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         busy      <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  is_write  <= cmd_write;
                  if (cmd_illegal(cmd_write, cmd_addr)) begin
                     state <= ERR;
                  end else begin
                     state   <= SHIFT;
                     tx_sr   <= {cmd_addr, cmd_write ? cmd_wdata : 8'h00};
                     pico    <= cmd_addr[7];
                     bit_cnt <= '0;
                     rx_sr   <= '0;
                  end
               end
            end
            SHIFT: begin
               if (sclk_rise && bit_cnt[3]) begin
                  rx_sr <= {rx_sr[6:0], poci};
               end
               if (sclk_fall) begin
                  if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                     state   <= GAP;
                     gap_cnt <= GW'(IDLE_CYCLES - 1);
                     pico    <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                     tx_sr   <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                     pico    <= tx_sr[FRAME_BITS-2];
                  end
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= is_write ? 8'h00 : rx_sr;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            ERR: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b1;
               rsp_rdata <= 8'h00;
            end
            RESP: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               rsp_err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
